can_bit_timing: RTL

Bit-timing front end for the CAN decoder. It samples the raw bus line RX, performs hard synchronisation on start-of-frame and SJW-limited resynchronisation inside a frame, and emits the one-cycle sample-point strobe SP and the sampled bit value. It sits directly upstream of the frame-maker stage, whose RX/SP inputs it drives; that stage's ERROR output is fed back here.

---
 rtl/can_bit_timing_if.sv | 33 +++
 rtl/can_bit_timing.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/can_bit_timing_if.sv
// ---------------------------------------------------------------------------
// can_bit_timing_if
// Groups the bus-side signals of the CAN bit-timing front end.
//   RX        raw bus line into the bit-timing block (1 = recessive)
//   ERROR     error flag fed back from the frame stage
//   SP        one-clock sample-point strobe
//   RX_S      sampled bit value
//   BIT_START one-clock strobe at the first clock of each SYNC_SEG
//   BUS_IDLE  high while the bit-timing block is idle
//   HSYNC     one-clock strobe on a hard synchronisation
// Modports:
//   master : the side that drives RX/ERROR and consumes the timing outputs
//   slave  : the bit-timing block itself
// ---------------------------------------------------------------------------
interface can_bit_timing_if;
  logic RX;
  logic ERROR;
  logic SP;
  logic RX_S;
  logic BIT_START;
  logic BUS_IDLE;
  logic HSYNC;

  modport master (
    output RX, ERROR,
    input  SP, RX_S, BIT_START, BUS_IDLE, HSYNC
  );

  modport slave (
    input  RX, ERROR,
    output SP, RX_S, BIT_START, BUS_IDLE, HSYNC
  );
endinterface

// File: rtl/can_bit_timing.sv
// ---------------------------------------------------------------------------
// can_bit_timing
// Bit-timing front end for the CAN decoder: synchronises RX, hard-syncs on
// start-of-frame, resynchronises (SJW-limited) inside a frame and produces
// the sample-point strobe plus the sampled bit.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous active-high reset
//   bus    can_bit_timing_if.slave (RX, ERROR in; SP, RX_S, BIT_START,
//          BUS_IDLE, HSYNC out)
// Parameters: BRP (clocks per tq), TSEG1, TSEG2, SJW (all in tq).
// Optional feature: define TRIPLE_SAMPLE_EN to take RX_S as the majority of
// rx_q at the sample point and the two preceding tq ticks (needs TSEG1>=3).
// ---------------------------------------------------------------------------
module can_bit_timing #(
  parameter int BRP   = 4,
  parameter int TSEG1 = 5,
  parameter int TSEG2 = 2,
  parameter int SJW   = 1
) (
  input  logic            clock,
  input  logic            reset,
  can_bit_timing_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  localparam int TQW = 6;
  localparam int QW  = 6;

  localparam logic [TQW-1:0] TQ_LAST = TQW'(BRP - 1);
  localparam logic [QW-1:0]  Q_SP    = QW'(TSEG1);
  localparam logic [QW-1:0]  Q_TSEG2 = QW'(TSEG2);
  localparam logic [QW-1:0]  Q_BIT   = QW'(1 + TSEG1 + TSEG2);
  localparam logic [QW-1:0]  Q_SJW   = QW'(SJW);

`ifdef TRIPLE_SAMPLE_EN
  if (TSEG1 < 3) begin : g_tseg1_check
    $error("can_bit_timing: TRIPLE_SAMPLE_EN requires TSEG1 >= 3");
  end
`endif

  function automatic logic [QW-1:0] clamp_sjw(input logic [QW-1:0] v);
    return (v > Q_SJW) ? Q_SJW : v;
  endfunction

  // Registers
  logic           sync1_q, rx_q, rx_prev_q;
  logic [0:0]     state_q, state_d;
  logic [TQW-1:0] tq_cnt_q, tq_cnt_d;
  logic [QW-1:0]  q_q, q_d;
  logic [QW-1:0]  ext_q, ext_d;
  logic [QW-1:0]  shr_q, shr_d;
  logic           synced_q, synced_d;
  logic           rx_s_q, rx_s_d;
  logic [3:0]     rec_q, rec_d;
  logic           bs_q, bs_d;

  // Combinational decode
  logic           fall, in_frame, hs, run, err, tick, rs, late, early;
  logic           sp, bit_end, sample;
  logic [TQW-1:0] tq_e;
  logic [QW-1:0]  q_e, ext_e, shr_e, ext_n, shr_n;
  logic           synced_e;

  assign fall     = rx_prev_q & ~rx_q;
  assign in_frame = (state_q == ST_FRAME);
  assign hs       = ~in_frame & fall;
  assign run      = in_frame | hs;
  assign err      = in_frame & bus.ERROR;

  // A hard sync makes the current clock the first clock of SYNC_SEG, so the
  // bit counters are viewed as zero in that cycle.
  assign tq_e     = hs ? '0 : tq_cnt_q;
  assign q_e      = hs ? '0 : q_q;
  assign ext_e    = hs ? '0 : ext_q;
  assign shr_e    = hs ? '0 : shr_q;
  assign synced_e = hs ? 1'b0 : synced_q;
  assign tick     = (tq_e == TQ_LAST);

  // Resync uses the pre-tick q; the new ext/shr apply on this very tick.
  assign rs    = in_frame & fall & rx_s_q & ~synced_q;
  assign late  = rs & (q_q != '0) & (q_q <= Q_SP);
  assign early = rs & (q_q > Q_SP);
  assign ext_n = late  ? clamp_sjw(q_q) : ext_e;
  assign shr_n = early ? clamp_sjw(Q_BIT - q_q) : shr_e;

  assign sp      = run & tick & (q_e == Q_SP + ext_n);
  // ">=" lets an early edge whose shortened end is already behind us end
  // the bit on the current tick.
  assign bit_end = run & tick & (q_e >= Q_SP + ext_n + Q_TSEG2 - shr_n);

`ifdef TRIPLE_SAMPLE_EN
  logic [1:0] hist_q, hist_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign sample = maj3(rx_q, hist_q[1], hist_q[0]);

  always_comb begin
    hist_d = hist_q;
    if (run && tick) hist_d = {hist_q[0], rx_q};
  end

  always_ff @(posedge clock) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= hist_d;
  end
`else
  assign sample = rx_q;
`endif

  always_comb begin
    state_d  = state_q;
    tq_cnt_d = tq_cnt_q;
    q_d      = q_q;
    ext_d    = ext_q;
    shr_d    = shr_q;
    synced_d = synced_q;
    rx_s_d   = rx_s_q;
    rec_d    = rec_q;
    bs_d     = 1'b0;
    if (err) begin
      // ERROR overrides resync and bit end
      state_d = ST_IDLE;
      rec_d   = '0;
    end else if (run) begin
      state_d  = ST_FRAME;
      tq_cnt_d = tick ? '0 : tq_e + 6'd1;
      q_d      = bit_end ? '0 : (tick ? q_e + 6'd1 : q_e);
      ext_d    = bit_end ? '0 : ext_n;
      shr_d    = bit_end ? '0 : shr_n;
      synced_d = bit_end ? 1'b0 : (synced_e | rs);
      bs_d     = bit_end;
      rec_d    = hs ? '0 : rec_q;
      if (sp) begin
        rx_s_d = sample;
        if (sample) begin
          rec_d = rec_q + 4'd1;
          // 11th consecutive recessive sample: bus is idle
          if (rec_q == 4'd10) state_d = ST_IDLE;
        end else begin
          rec_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_q      <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      tq_cnt_q  <= 6'd1;
      q_q       <= 6'd1;
      ext_q     <= '0;
      shr_q     <= '0;
      synced_q  <= 1'b0;
      rx_s_q    <= 1'b1;
      rec_q     <= 4'd1;
      bs_q      <= 1'b0;
    end else begin
      sync1_q   <= bus.RX;
      rx_q      <= sync1_q;
      rx_prev_q <= rx_q;
      state_q   <= state_d;
      tq_cnt_q  <= tq_cnt_d;
      q_q       <= q_d;
      ext_q     <= ext_d;
      shr_q     <= shr_d;
      synced_q  <= synced_d;
      rx_s_q    <= rx_s_d;
      rec_q     <= rec_d;
      bs_q      <= bs_d;
    end
  end

  // Strobes are masked while reset is asserted so a mid-bit reset never
  // produces a sample point.
  assign bus.SP        = sp & ~reset;
  assign bus.HSYNC     = hs & ~reset;
  assign bus.BIT_START = (bs_q | hs) & ~reset;
  assign bus.RX_S      = (sp & ~reset) ? sample : rx_s_q;
  assign bus.BUS_IDLE  = ~in_frame & ~hs;

endmodule
